// File: rtl/vga_row_marker_renderer.sv
// VGA timing generator that paints marked rows from a per-frame snapshot of the row-marker vector.
// Every output is registered one clock after the (hc,vc) position it describes.
module vga_row_marker_renderer #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] MARK_RGB = 12'hF00,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [V_ACTIVE-1:0] storage_bytes,
    input  logic                storage_finished,
    output logic                hsync,
    output logic                vsync,
    output logic                video_active,
    output logic [9:0]          h_count,
    output logic [9:0]          v_count,
    output logic [11:0]         rgb,
    output logic                frame_start,
    output logic                frame_stale
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int         VIW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic [9:0]          hc, vc;
    logic [V_ACTIVE-1:0] shadow;
    logic                h_wrap, v_wrap, active, snap;
    logic [VIW-1:0]      row;

    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);
    assign active = (hc < H_ACT) && (vc < V_ACT);
    assign snap   = (hc == 10'd0) && v_wrap;
    assign row    = vc[VIW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (h_wrap) begin
            hc <= '0;
            vc <= v_wrap ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Snapshot sits on the last (blank) line so the whole next frame sees one stable vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            frame_stale <= 1'b0;
        end else if (snap) begin
            if (storage_finished) shadow <= storage_bytes;
            frame_stale <= ~storage_finished;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            video_active <= 1'b0;
            h_count      <= '0;
            v_count      <= '0;
            rgb          <= '0;
            frame_start  <= 1'b0;
        end else begin
            hsync        <= ~((hc >= HS_BEG) && (hc < HS_END));
            vsync        <= ~((vc >= VS_BEG) && (vc < VS_END));
            video_active <= active;
            h_count      <= hc;
            v_count      <= vc;
            rgb          <= active ? (shadow[row] ? MARK_RGB : BG_RGB) : 12'h000;
            frame_start  <= (hc == 10'd0) && (vc == 10'd0);
        end
    end
endmodule

// File: tb/tb_vga_row_marker_renderer.sv
// Bench for vga_row_marker_renderer using a shrunken timing set so many frames fit in a short run.
// A linear pixel-index model derives expected outputs from the timing and snapshot rules.
module tb_vga_row_marker_renderer;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int SNAP = (VT - 1) * HT;
    localparam logic [11:0] MARK = 12'hF00;
    localparam logic [11:0] BG   = 12'h012;
    localparam logic [36:0] RST_V = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0, 1'b0, 1'b0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VA-1:0] sb = '0;
    logic          fin = 1'b0;
    logic          hsync, vsync, video_active, frame_start, frame_stale;
    logic [9:0]    h_count, v_count;
    logic [11:0]   rgb;

    int n_checks = 0;
    int n_fail = 0;

    vga_row_marker_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .MARK_RGB(MARK), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .storage_bytes(sb), .storage_finished(fin),
        .hsync(hsync), .vsync(vsync), .video_active(video_active),
        .h_count(h_count), .v_count(v_count), .rgb(rgb),
        .frame_start(frame_start), .frame_stale(frame_stale)
    );

    always #5 clk = ~clk;

    // Model: position p = clocks since release modulo one frame.
    int            mcnt = 0;
    logic [VA-1:0] m_shadow = '0;
    logic          m_stale = 1'b0;
    logic [36:0]   exp_v = RST_V;

    function automatic logic [36:0] model_out(int p, logic [VA-1:0] shd, logic st);
        int h, v;
        logic act;
        logic [11:0] c;
        h = p % HT;
        v = p / HT;
        act = (h < HA) && (v < VA);
        c = 12'h000;
        if (act) c = shd[v] ? MARK : BG;
        return {~(h >= HA + HF && h < HA + HF + HS), ~(v >= VA + VF && v < VA + VF + VS),
                act, 10'(h), 10'(v), c, (p == 0), st};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt     <= 0;
            m_shadow <= '0;
            m_stale  <= 1'b0;
            exp_v    <= RST_V;
        end else begin
            exp_v <= model_out(mcnt, m_shadow, (mcnt == SNAP) ? ~fin : m_stale);
            if (mcnt == SNAP) begin
                if (fin) m_shadow <= sb;
                m_stale <= ~fin;
            end
            mcnt <= (mcnt + 1) % FRAME;
        end
    end

    function automatic logic [36:0] dut_vec();
        return {hsync, vsync, video_active, h_count, v_count, rgb, frame_start, frame_stale};
    endfunction

    task automatic wait_pos(input int p);
        int k;
        k = 0;
        @(negedge clk);
        while (mcnt != p && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (mcnt != p) begin
            n_fail++;
            $display("FAIL wait_pos timeout: reached %0d, required %0d", mcnt, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== RST_V) begin
                n_fail++;
                $display("FAIL reset_hold got=%h exp=%h", dut_vec(), RST_V);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({frame_start, h_count, v_count} !== {1'b1, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL first_pixel got fs=%b h=%0d v=%0d exp fs=1 h=0 v=0", frame_start, h_count, v_count);
        end
        n_checks++;
        if (dut_vec() !== exp_v) begin
            n_fail++;
            $display("FAIL first_pixel_model got=%h exp=%h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_timing();
        int hs_low, vs_low, fs_cnt, last_fall, period, errs;
        logic prev_hs;
        hs_low = 0; vs_low = 0; fs_cnt = 0; last_fall = -1; period = 0; errs = 0;
        prev_hs = hsync;
        fin = 1'b1;
        sb = VA'($urandom);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs < 5) $display("FAIL timing_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
            end
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (prev_hs && !hsync) begin
                if (last_fall >= 0) period = i - last_fall;
                last_fall = i;
            end
            prev_hs = hsync;
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL timing_model %0d pixel mismatches, required 0", errs); end
        n_checks++;
        if (hs_low != HS * VT) begin n_fail++; $display("FAIL hsync_low got=%0d exp=%0d", hs_low, HS * VT); end
        n_checks++;
        if (vs_low != VS * HT) begin n_fail++; $display("FAIL vsync_low got=%0d exp=%0d", vs_low, VS * HT); end
        n_checks++;
        if (fs_cnt != 1) begin n_fail++; $display("FAIL frame_start_count got=%0d exp=1", fs_cnt); end
        n_checks++;
        if (period != HT) begin n_fail++; $display("FAIL hsync_period got=%0d exp=%0d", period, HT); end
    endtask

    task automatic test_single_row();
        int reds, stray, errs;
        reds = 0; stray = 0; errs = 0;
        sb = '0; sb[4] = 1'b1; fin = 1'b1;
        wait_pos(0);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs < 5) $display("FAIL single_row_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
            end
            if (rgb == MARK) begin
                reds++;
                if (v_count != 10'd4) stray++;
            end
            if (!video_active && rgb != 12'h000) stray++;
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL single_row_model %0d mismatches, required 0", errs); end
        n_checks++;
        if (reds != HA) begin n_fail++; $display("FAIL single_row_reds got=%0d exp=%0d", reds, HA); end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL single_row_stray got=%0d exp=0", stray); end
    endtask

    task automatic test_tearing();
        int reds, reds2, errs;
        reds = 0; reds2 = 0; errs = 0;
        sb = '0; sb[0] = 1'b1; sb[VA-1] = 1'b1; fin = 1'b1;
        wait_pos(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs < 5) $display("FAIL tearing_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
            end
            if (rgb == MARK) begin
                if (i < FRAME) reds++;
                else if (v_count == 10'd5) reds2++;
            end
            if (mcnt == (VA / 2) * HT && i < FRAME) begin
                sb = '0; sb[5] = 1'b1;
            end
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL tearing_model %0d mismatches, required 0", errs); end
        n_checks++;
        if (reds != 2 * HA) begin n_fail++; $display("FAIL tearing_current got=%0d exp=%0d", reds, 2 * HA); end
        n_checks++;
        if (reds2 != HA) begin n_fail++; $display("FAIL tearing_next got=%0d exp=%0d", reds2, HA); end
    endtask

    task automatic test_stale();
        int errs;
        errs = 0;
        sb = '0; sb[3] = 1'b1; fin = 1'b1;
        wait_pos(0);
        sb = '0; sb[7] = 1'b1; fin = 1'b0;
        wait_pos(0);
        n_checks++;
        if (frame_stale !== 1'b1) begin n_fail++; $display("FAIL stale_set got=%b exp=1", frame_stale); end
        fin = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs < 5) $display("FAIL stale_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
            end
            if (i == FRAME - SNAP / 2 && rgb == MARK && v_count != 10'd3) errs++;
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL stale_model %0d mismatches, required 0", errs); end
        n_checks++;
        if (frame_stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear got=%b exp=0", frame_stale); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                if (dut_vec() !== exp_v) begin
                    errs++;
                    if (errs < 5) $display("FAIL random_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
                end
                if ($urandom_range(0, 39) == 0) sb = VA'($urandom);
                if ($urandom_range(0, 39) == 0) fin = 1'($urandom);
            end
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL random_model %0d mismatches, required 0", errs); end
    endtask

    task automatic test_reset_midframe();
        int reds, reds2, errs;
        reds = 0; reds2 = 0; errs = 0;
        sb = '1; fin = 1'b1;
        wait_pos(0);
        wait_pos((VA / 2) * HT + HA / 2);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== RST_V) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), RST_V); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs < 5) $display("FAIL post_reset_model pos=%0d got=%h exp=%h", mcnt, dut_vec(), exp_v);
            end
            if (rgb == MARK) begin
                if (i < FRAME) reds++;
                else reds2++;
            end
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL post_reset_model %0d mismatches, required 0", errs); end
        n_checks++;
        if (reds != 0) begin n_fail++; $display("FAIL post_reset_blank got=%0d exp=0", reds); end
        n_checks++;
        if (reds2 != HA * VA) begin n_fail++; $display("FAIL post_reset_refill got=%0d exp=%0d", reds2, HA * VA); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_single_row();
        test_tearing();
        test_stale();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
